// File: rtl/timing_generator.sv
// timing_generator: master timing generator for the 4004 core.
//
// Divides sysclk into the non-overlapping clk1/clk2 enables (one sysclk each per
// 4-sysclk subcycle) and sequences the eight subcycles A1 A2 A3 M1 M2 X1 X2 X3.
// Also generates the internal power-on clear, held through one full clean
// instruction cycle after reset release.
//
// Optional feature macro: TIMING_EXT_SYNC_EN
//   When defined, the sync_in port exists. A high sync_in sampled at a clk2 edge
//   forces the next subcycle to A1, re-aligning a slave to the master's X3.
//
// Ports:
//   sysclk   in   system clock, all state updates on the rising edge
//   poc_n    in   asynchronous active-low reset (RESET pin)
//   sync_in  in   external X3 marker (TIMING_EXT_SYNC_EN builds only)
//   clk1     out  phase-1 enable
//   clk2     out  phase-2 enable
//   a12..x32 out  one-hot subcycle strobes A1..X3
//   sync     out  high during X3 (same as x32)
//   poc      out  active-high internal power-on clear
module timing_generator (
  input  logic sysclk,
  input  logic poc_n,
`ifdef TIMING_EXT_SYNC_EN
  input  logic sync_in,
`endif
  output logic clk1,
  output logic clk2,
  output logic a12,
  output logic a22,
  output logic a32,
  output logic m12,
  output logic m22,
  output logic x12,
  output logic x22,
  output logic x32,
  output logic sync,
  output logic poc
);

  typedef enum logic [2:0] {
    ScA1 = 3'd0,
    ScA2 = 3'd1,
    ScA3 = 3'd2,
    ScM1 = 3'd3,
    ScM2 = 3'd4,
    ScX1 = 3'd5,
    ScX2 = 3'd6,
    ScX3 = 3'd7
  } subcycle_e;

  logic       rel_q1, rel_q2;
  logic [1:0] ph_q, ph_d;
  logic       clk1_q, clk2_q;
  subcycle_e  subcycle_q, subcycle_d;
  logic [7:0] strobe_q, strobe_d;
  logic       armed_q, poc_q;
  logic       ext_sync;
  logic       wrap;

`ifdef TIMING_EXT_SYNC_EN
  assign ext_sync = sync_in;
`else
  assign ext_sync = 1'b0;
`endif

  // Two-flop release synchroniser; assertion clears it asynchronously.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      rel_q1 <= 1'b0;
      rel_q2 <= 1'b0;
    end else begin
      rel_q1 <= 1'b1;
      rel_q2 <= rel_q1;
    end
  end

  always_comb begin
    ph_d       = ph_q + 2'd1;
    // An X3->A1 transition, natural or forced by sync_in, only at a clk2 edge.
    wrap       = clk2_q && ((subcycle_q == ScX3) || ext_sync);
    subcycle_d = subcycle_q;
    if (clk2_q) begin
      subcycle_d = wrap ? ScA1 : subcycle_e'(3'(subcycle_q + 3'd1));
    end
    strobe_d   = 8'd1 << subcycle_d;
  end

  // State is already at reset values when rel_q2 is low (it can only be low
  // after an assertion), so simply holding keeps everything in reset.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      ph_q       <= 2'd3;
      clk1_q     <= 1'b0;
      clk2_q     <= 1'b0;
      subcycle_q <= ScX3;
      strobe_q   <= 8'h80;
      armed_q    <= 1'b0;
      poc_q      <= 1'b1;
    end else if (rel_q2) begin
      ph_q       <= ph_d;
      clk1_q     <= (ph_d == 2'd0);
      clk2_q     <= (ph_d == 2'd2);
      subcycle_q <= subcycle_d;
      strobe_q   <= strobe_d;
      // First wrap after release arms, second clears poc.
      if (wrap) begin
        if (!armed_q) begin
          armed_q <= 1'b1;
        end else begin
          poc_q <= 1'b0;
        end
      end
    end
  end

  assign clk1 = clk1_q;
  assign clk2 = clk2_q;
  assign a12  = strobe_q[0];
  assign a22  = strobe_q[1];
  assign a32  = strobe_q[2];
  assign m12  = strobe_q[3];
  assign m22  = strobe_q[4];
  assign x12  = strobe_q[5];
  assign x22  = strobe_q[6];
  assign x32  = strobe_q[7];
  assign sync = strobe_q[7];
  assign poc  = poc_q;

endmodule
